// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the PWM generator: default widths, the last counter
// value of a period, and the controller state encoding.
// -----------------------------------------------------------------------------
package pwm_pkg;

    localparam int WIDTH_DEF      = 8;
    localparam int PRESCALE_W_DEF = 8;

    // Counter runs 0..PERIOD_MAX, so a period is 2**WIDTH-1 ticks long and a
    // full-scale duty word (all ones) is never reached by the counter.
    localparam int PERIOD_MAX = 2**WIDTH_DEF - 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pwm_state_t;

    // Last counter value of a period for an arbitrary counter width.
    function automatic int period_max(input int w);
        return (2**w) - 2;
    endfunction

endpackage : pwm_pkg

// File: rtl/pwm_prescaler.sv
// -----------------------------------------------------------------------------
// pwm_prescaler
// Clock-enable generator for the PWM counter. While run is high the internal
// count steps 0..prescale and tick is asserted on the clock where the count
// has reached (or passed) prescale; the count then restarts at 0.
//
// Ports
//   clk       in   system clock, posedge
//   reset     in   synchronous, active-low
//   run       in   1 = count, 0 = hold count at 0 (no ticks)
//   prescale  in   tick period minus one, sampled live every clock
//   tick      out  combinational tick strobe, valid in the same clock
// -----------------------------------------------------------------------------
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PRESCALE_W = PRESCALE_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] count_q;
    logic [PRESCALE_W-1:0] count_d;

    // >= rather than == so that lowering prescale below the current count
    // forces an immediate tick instead of waiting for the count to wrap.
    assign tick = run && (count_q >= prescale);

    always_comb begin
        count_d = count_q;
        if (!run || tick) begin
            count_d = '0;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : pwm_prescaler

// File: rtl/pwm_gen.sv
// -----------------------------------------------------------------------------
// pwm_gen
// Edge-aligned PWM generator with a double-buffered duty register, a
// complementary output and a programmable clock prescaler. A new duty word is
// captured on the rising edge of duty_load into a shadow register and only
// becomes active at the next period boundary, so no runt pulses are produced.
//
// Ports
//   clk           in   system clock, posedge
//   reset         in   synchronous, active-low
//   enable        in   1 = run, 0 = idle (outputs forced low)
//   duty_in       in   duty word from the upstream shift register
//   duty_load     in   load strobe, rising edge captured once per assertion
//   prescale      in   counter advances every prescale+1 clocks
//   pwm_out       out  registered PWM output
//   pwm_out_n     out  complement of pwm_out while running, 0 when idle
//   period_start  out  one-clock pulse in the clock where the counter is 0
//                      after a wrap
//   duty_active   out  duty word currently used by the comparator
// -----------------------------------------------------------------------------
module pwm_gen
    import pwm_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int PRESCALE_W = PRESCALE_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [WIDTH-1:0]      duty_in,
    input  logic                  duty_load,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  pwm_out,
    output logic                  pwm_out_n,
    output logic                  period_start,
    output logic [WIDTH-1:0]      duty_active
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(period_max(WIDTH));

    pwm_state_t       state_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] duty_active_q;
    logic [WIDTH-1:0] shadow_q;
    logic             pending_q;
    logic             load_q;
    logic             pwm_q;
    logic             pwm_n_q;
    logic             pstart_q;

    logic             run;
    logic             tick;
    logic             load_ev;
    logic             wrap;
    logic             below;

    // The prescaler only runs while the controller is in RUN and is still
    // enabled, so it is already cleared on the clock that drops back to IDLE.
    assign run = (state_q == RUN) && enable;

    pwm_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .prescale (prescale),
        .tick     (tick)
    );

    assign load_ev = duty_load && !load_q;
    assign wrap    = tick && (cnt_q == CNT_MAX);
    assign cnt_d   = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    assign below   = (cnt_q < duty_active_q);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            duty_active_q <= '0;
            shadow_q      <= '0;
            pending_q     <= 1'b0;
            load_q        <= 1'b0;
            pwm_q         <= 1'b0;
            pwm_n_q       <= 1'b0;
            pstart_q      <= 1'b0;
        end else begin
            load_q <= duty_load;

            // Loads are accepted in every state; the assignments in the state
            // branches below may override pending_q for the same clock.
            if (load_ev) begin
                shadow_q  <= duty_in;
                pending_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    cnt_q         <= '0;
                    pwm_q         <= 1'b0;
                    pwm_n_q       <= 1'b0;
                    pstart_q      <= 1'b0;
                    duty_active_q <= shadow_q;
                    // A load arriving on the IDLE clock is not yet in
                    // shadow_q, so it stays pending in case we leave IDLE now.
                    if (!load_ev) begin
                        pending_q <= 1'b0;
                    end
                    if (enable) begin
                        state_q <= RUN;
                    end
                end

                RUN: begin
                    if (!enable) begin
                        state_q  <= IDLE;
                        cnt_q    <= '0;
                        pwm_q    <= 1'b0;
                        pwm_n_q  <= 1'b0;
                        pstart_q <= 1'b0;
                    end else begin
                        pwm_q    <= below;
                        pwm_n_q  <= !below;
                        pstart_q <= wrap;
                        if (tick) begin
                            cnt_q <= cnt_d;
                        end
                        // Period boundary: a load on this very clock bypasses
                        // the shadow so the newest value wins.
                        if (wrap) begin
                            if (load_ev) begin
                                duty_active_q <= duty_in;
                                pending_q     <= 1'b0;
                            end else if (pending_q) begin
                                duty_active_q <= shadow_q;
                                pending_q     <= 1'b0;
                            end
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pwm_out      = pwm_q;
    assign pwm_out_n    = pwm_n_q;
    assign period_start = pstart_q;
    assign duty_active  = duty_active_q;

endmodule : pwm_gen

// File: tb/tb_pwm_gen.sv
// -----------------------------------------------------------------------------
// tb_pwm_gen
// Directed testbench for pwm_gen with hand-computed expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pwm_gen;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [7:0] duty_in;
    logic       duty_load;
    logic [7:0] prescale;
    logic       pwm_out;
    logic       pwm_out_n;
    logic       period_start;
    logic [7:0] duty_active;

    int vectors;
    int miscompares;

    pwm_gen #(
        .WIDTH      (8),
        .PRESCALE_W (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .duty_in      (duty_in),
        .duty_load    (duty_load),
        .prescale     (prescale),
        .pwm_out      (pwm_out),
        .pwm_out_n    (pwm_out_n),
        .period_start (period_start),
        .duty_active  (duty_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] v);
        duty_in   = v;
        duty_load = 1'b1;
        tick();
        duty_load = 1'b0;
        tick();
    endtask

    // Advance until period_start is seen, at most limit clocks.
    task automatic wait_start(input string tag, input int limit);
        int seen;
        seen = 0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (period_start === 1'b1) begin
                seen = 1;
                break;
            end
        end
        chk(tag, seen, 1);
    endtask

    task automatic measure(input int n, output int highs, output int starts, output int cerr);
        highs  = 0;
        starts = 0;
        cerr   = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (pwm_out === 1'b1) highs++;
            if (period_start === 1'b1) starts++;
            if (pwm_out_n !== ~pwm_out) cerr++;
        end
    endtask

    initial begin
        int highs, starts, cerr, errs, cycles, found;
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        enable      = 1'b0;
        duty_in     = 8'd0;
        duty_load   = 1'b0;
        prescale    = 8'd0;

        // Reset state
        repeat (3) tick();
        chk("rst_pwm", pwm_out, 0);
        chk("rst_pwm_n", pwm_out_n, 0);
        chk("rst_pstart", period_start, 0);
        chk("rst_duty", duty_active, 0);
        reset = 1'b1;
        tick();

        // Load in IDLE: active one clock after the shadow captures it
        duty_in   = 8'd64;
        duty_load = 1'b1;
        tick();
        chk("idle_load_lat0", duty_active, 0);
        duty_load = 1'b0;
        tick();
        chk("idle_load_lat1", duty_active, 64);

        // Duty 64, prescale 0: 64 high of 255, one period_start per period
        enable = 1'b1;
        wait_start("d64_start", 300);
        measure(255, highs, starts, cerr);
        chk("d64_highs", highs, 64);
        chk("d64_starts", starts, 1);
        chk("d64_last_start", period_start, 1);
        chk("d64_compl", cerr, 0);

        // Duty 0: never high
        load(8'd0);
        wait_start("d0_start", 300);
        chk("d0_active", duty_active, 0);
        measure(255, highs, starts, cerr);
        chk("d0_highs", highs, 0);
        chk("d0_compl", cerr, 0);

        // Duty 255: never low
        load(8'd255);
        wait_start("d255_start", 300);
        chk("d255_active", duty_active, 255);
        measure(255, highs, starts, cerr);
        chk("d255_highs", highs, 255);
        chk("d255_compl", cerr, 0);

        // Duty 100, then 200 loaded mid-period: swap only at period_start
        load(8'd100);
        wait_start("d100_start", 300);
        chk("d100_active", duty_active, 100);
        repeat (50) tick();
        load(8'd200);
        chk("mid_hold", duty_active, 100);
        errs  = 0;
        found = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (period_start === 1'b1) begin
                found = 1;
                break;
            end
            if (duty_active !== 8'd100) errs++;
        end
        chk("mid_found", found, 1);
        chk("mid_no_early", errs, 0);
        chk("mid_swap", duty_active, 200);
        measure(255, highs, starts, cerr);
        chk("d200_highs", highs, 200);
        chk("d200_compl", cerr, 0);

        // Prescale 3, duty 128: 1020-clock period, 512 high
        prescale = 8'd3;
        load(8'd128);
        wait_start("ps3_start", 1100);
        chk("ps3_active", duty_active, 128);
        measure(1020, highs, starts, cerr);
        chk("ps3_highs", highs, 512);
        chk("ps3_starts", starts, 1);
        chk("ps3_last_start", period_start, 1);
        prescale = 8'd0;

        // Enable drop: outputs forced low
        repeat (5) tick();
        enable = 1'b0;
        tick();
        chk("idle_pwm", pwm_out, 0);
        chk("idle_pwm_n", pwm_out_n, 0);
        chk("idle_pstart", period_start, 0);

        // Held load level with changing data: only first value captured
        duty_in   = 8'd10;
        duty_load = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            duty_in = 8'(10 + i);
        end
        duty_load = 1'b0;
        tick();
        tick();
        chk("held_load", duty_active, 10);

        // Fresh edge loads again
        load(8'd40);
        chk("reload", duty_active, 40);

        // Re-enable: counter restarts at 0, first wrap 256 clocks later
        enable = 1'b1;
        tick();
        chk("reen_first", pwm_out, 0);
        tick();
        chk("reen_cnt0", pwm_out, 1);
        highs  = 1;
        cycles = 2;
        found  = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            cycles++;
            if (pwm_out === 1'b1) highs++;
            if (period_start === 1'b1) begin
                found = 1;
                break;
            end
        end
        chk("reen_found", found, 1);
        chk("reen_cycles", cycles, 256);
        chk("reen_highs", highs, 40);

        // Reset mid-period
        repeat (10) tick();
        chk("pre_rst_pwm", pwm_out, 1);
        reset = 1'b0;
        tick();
        chk("mid_rst_pwm", pwm_out, 0);
        chk("mid_rst_pwm_n", pwm_out_n, 0);
        chk("mid_rst_pstart", period_start, 0);
        chk("mid_rst_duty", duty_active, 0);
        reset  = 1'b1;
        enable = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_pwm_gen
